fifo_status_ctrl: RTL and testbench

Parametrised FIFO status and pointer controller for the synchronous FIFO. It owns the read and write pointers and gates raw requests into accepted operations. It produces occupancy count, full/empty, half-threshold, programmable almost-full/almost-empty, overflow/underflow error flags and a high-watermark. It sits between the FIFO front end and the dual-port memory, which takes `fifo_we`, `fifo_rd`, `wptr` and `rptr` directly.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ptr_cnt.sv | 26 ++
 rtl/fifo_status_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_status_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing constants and helpers for the FIFO status controller
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int ptr_w_of(input int aw);
    return aw + 1;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_W_DEF);
  localparam int PTR_W_DEF = ptr_w_of(ADDR_W_DEF);

endpackage

// File: rtl/fifo_ptr_cnt.sv
// rtl/fifo_ptr_cnt.sv - wrap-bit pointer incrementer with enable and synchronous reset
module fifo_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int W = PTR_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Natural overflow from all-ones to zero toggles the wrap bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fifo_status_ctrl.sv
// rtl/fifo_status_ctrl.sv - FIFO pointer ownership, request gating, status/error flags and watermark
module fifo_status_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic          rd,
  input  logic [ADDR_W:0] af_level,
  input  logic [ADDR_W:0] ae_level,
  input  logic          err_clr,
  input  logic          wm_clr,
  output logic          fifo_we,
  output logic          fifo_rd,
  output logic [ADDR_W:0] wptr,
  output logic [ADDR_W:0] rptr,
  output logic [ADDR_W:0] fifo_count,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          fifo_threshold,
  output logic          fifo_almost_full,
  output logic          fifo_almost_empty,
  output logic          fifo_overflow,
  output logic          fifo_underflow,
  output logic [ADDR_W:0] peak_count
);

  localparam int              PTR_W  = ptr_w_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_V = PTR_W'(depth_of(ADDR_W));
  localparam logic [ADDR_W:0] HALF_V  = PTR_W'(depth_of(ADDR_W) / 2);

  logic            w_we;
  logic            w_rd;
  logic [ADDR_W:0] w_wptr;
  logic [ADDR_W:0] w_rptr;
  logic [ADDR_W:0] w_wptr_nxt;
  logic [ADDR_W:0] w_rptr_nxt;
  logic [ADDR_W:0] w_cnt_nxt;
  logic            w_ovf_set;
  logic            w_unf_set;
  logic            w_ovf_clr;
  logic            w_unf_clr;

  logic            r_full;
  logic            r_empty;
  logic            r_thr;
  logic            r_af;
  logic            r_ae;
  logic            r_ovf;
  logic            r_unf;
  logic [ADDR_W:0] r_peak;

  // Gating from registered flags means a full FIFO never passes a write through on a read.
  assign w_we = rst_n & wr & ~r_full;
  assign w_rd = rst_n & rd & ~r_empty;

  assign w_wptr_nxt = w_wptr + {{ADDR_W{1'b0}}, w_we};
  assign w_rptr_nxt = w_rptr + {{ADDR_W{1'b0}}, w_rd};
  assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;

  assign w_ovf_set = wr & r_full;
  assign w_unf_set = rd & r_empty;
  assign w_ovf_clr = err_clr | (~STICKY_ERR & w_rd);
  assign w_unf_clr = err_clr | (~STICKY_ERR & w_we);

  fifo_ptr_cnt #(.W(PTR_W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_we),
    .o_q   (w_wptr)
  );

  fifo_ptr_cnt #(.W(PTR_W)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_rd),
    .o_q   (w_rptr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_thr   <= 1'b0;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_peak  <= '0;
    end else begin
      r_full  <= (w_cnt_nxt == DEPTH_V);
      r_empty <= (w_cnt_nxt == '0);
      r_thr   <= (w_cnt_nxt >= HALF_V);
      r_af    <= (w_cnt_nxt >= af_level);
      r_ae    <= (w_cnt_nxt <= ae_level);

      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;

      if (w_unf_set)      r_unf <= 1'b1;
      else if (w_unf_clr) r_unf <= 1'b0;

      if (wm_clr || (w_cnt_nxt > r_peak)) r_peak <= w_cnt_nxt;
    end
  end

  assign fifo_we           = w_we;
  assign fifo_rd           = w_rd;
  assign wptr              = w_wptr;
  assign rptr              = w_rptr;
  assign fifo_count        = w_wptr - w_rptr;
  assign fifo_full         = r_full;
  assign fifo_empty        = r_empty;
  assign fifo_threshold    = r_thr;
  assign fifo_almost_full  = r_af;
  assign fifo_almost_empty = r_ae;
  assign fifo_overflow     = r_ovf;
  assign fifo_underflow    = r_unf;
  assign peak_count        = r_peak;

endmodule

// File: tb/tb_fifo_status_ctrl.sv
// tb/tb_fifo_status_ctrl.sv - directed plus random scoreboard bench for fifo_status_ctrl
module tb_fifo_status_ctrl;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic [4:0] af_level;
  logic [4:0] ae_level;
  logic       err_clr;
  logic       wm_clr;

  logic       fifo_we, fifo_rd;
  logic [4:0] wptr, rptr, fifo_count, peak_count;
  logic       fifo_full, fifo_empty, fifo_threshold, fifo_almost_full, fifo_almost_empty;
  logic       fifo_overflow, fifo_underflow;

  logic       l_we, l_rd;
  logic [4:0] l_wptr, l_rptr, l_count, l_peak;
  logic       l_full, l_empty, l_thr, l_af, l_ae, l_ovf, l_unf;

  fifo_status_ctrl #(.ADDR_W(4), .STICKY_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd),
    .af_level(af_level), .ae_level(ae_level), .err_clr(err_clr), .wm_clr(wm_clr),
    .fifo_we(fifo_we), .fifo_rd(fifo_rd), .wptr(wptr), .rptr(rptr),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_threshold(fifo_threshold), .fifo_almost_full(fifo_almost_full),
    .fifo_almost_empty(fifo_almost_empty), .fifo_overflow(fifo_overflow),
    .fifo_underflow(fifo_underflow), .peak_count(peak_count)
  );

  fifo_status_ctrl #(.ADDR_W(4), .STICKY_ERR(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd),
    .af_level(af_level), .ae_level(ae_level), .err_clr(err_clr), .wm_clr(wm_clr),
    .fifo_we(l_we), .fifo_rd(l_rd), .wptr(l_wptr), .rptr(l_rptr),
    .fifo_count(l_count), .fifo_full(l_full), .fifo_empty(l_empty),
    .fifo_threshold(l_thr), .fifo_almost_full(l_af),
    .fifo_almost_empty(l_ae), .fifo_overflow(l_ovf),
    .fifo_underflow(l_unf), .peak_count(l_peak)
  );

  typedef struct {
    int wptr, rptr, count, peak;
    bit full, empty, thr, af, ae, ovf, unf, ovf_l, unf_l;
  } exp_t;

  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  int m_w = 0, m_r = 0, m_cnt = 0, m_peak = 0;
  bit m_full = 0, m_empty = 1, m_thr = 0, m_af = 0, m_ae = 1;
  bit m_ovf = 0, m_unf = 0, m_ovf_l = 0, m_unf_l = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit i_wr, input bit i_rd, input bit i_ec, input bit i_wc, input bit i_rstn);
    exp_t e;
    bit ew, er, ovs, uns;
    wr = i_wr; rd = i_rd; err_clr = i_ec; wm_clr = i_wc; rst_n = i_rstn;
    #1;
    ew = i_rstn & i_wr & ~m_full;
    er = i_rstn & i_rd & ~m_empty;
    chk("fifo_we", int'(fifo_we), int'(ew));
    chk("fifo_rd", int'(fifo_rd), int'(er));
    if (!i_rstn) begin
      m_w = 0; m_r = 0; m_cnt = 0; m_peak = 0;
      m_full = 0; m_empty = 1; m_thr = 0; m_af = 0; m_ae = 1;
      m_ovf = 0; m_unf = 0; m_ovf_l = 0; m_unf_l = 0;
    end else begin
      ovs = i_wr & m_full;
      uns = i_rd & m_empty;
      m_w = (m_w + int'(ew)) % 32;
      m_r = (m_r + int'(er)) % 32;
      m_cnt = (m_w - m_r + 32) % 32;
      m_full = (m_cnt == DEPTH);
      m_empty = (m_cnt == 0);
      m_thr = (m_cnt >= DEPTH / 2);
      m_af = (m_cnt >= int'(af_level));
      m_ae = (m_cnt <= int'(ae_level));
      m_ovf   = ovs ? 1'b1 : (i_ec ? 1'b0 : m_ovf);
      m_unf   = uns ? 1'b1 : (i_ec ? 1'b0 : m_unf);
      m_ovf_l = ovs ? 1'b1 : ((i_ec | er) ? 1'b0 : m_ovf_l);
      m_unf_l = uns ? 1'b1 : ((i_ec | ew) ? 1'b0 : m_unf_l);
      if (i_wc || m_cnt > m_peak) m_peak = m_cnt;
    end
    e.wptr = m_w; e.rptr = m_r; e.count = m_cnt; e.peak = m_peak;
    e.full = m_full; e.empty = m_empty; e.thr = m_thr; e.af = m_af; e.ae = m_ae;
    e.ovf = m_ovf; e.unf = m_unf; e.ovf_l = m_ovf_l; e.unf_l = m_unf_l;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = q.pop_front();
      chk("wptr", int'(wptr), e.wptr);
      chk("rptr", int'(rptr), e.rptr);
      chk("count", int'(fifo_count), e.count);
      chk("peak", int'(peak_count), e.peak);
      chk("full", int'(fifo_full), int'(e.full));
      chk("empty", int'(fifo_empty), int'(e.empty));
      chk("threshold", int'(fifo_threshold), int'(e.thr));
      chk("almost_full", int'(fifo_almost_full), int'(e.af));
      chk("almost_empty", int'(fifo_almost_empty), int'(e.ae));
      chk("overflow", int'(fifo_overflow), int'(e.ovf));
      chk("underflow", int'(fifo_underflow), int'(e.unf));
      chk("overflow_legacy", int'(l_ovf), int'(e.ovf_l));
      chk("underflow_legacy", int'(l_unf), int'(e.unf_l));
    end
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; wm_clr = 1'b0;
    af_level = 5'd16; ae_level = 5'd0;
    #1;

    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_empty", int'(fifo_empty), 1);
    chk("reset_count", int'(fifo_count), 0);

    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 0, 1);
      if (i == 6) chk("thr_below_8", int'(fifo_threshold), 0);
      if (i == 7) chk("thr_at_8", int'(fifo_threshold), 1);
    end
    chk("full_after_16", int'(fifo_full), 1);
    chk("wptr_after_16", int'(wptr), 5'b10000);
    chk("rptr_after_16", int'(rptr), 0);
    chk("peak_after_16", int'(peak_count), 16);

    step(1, 0, 0, 0, 1);
    chk("ovf_set", int'(fifo_overflow), 1);
    chk("count_held_16", int'(fifo_count), 16);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    chk("ovf_sticky", int'(fifo_overflow), 1);
    step(0, 0, 1, 0, 1);
    chk("ovf_cleared", int'(fifo_overflow), 0);
    step(1, 0, 1, 0, 1);
    chk("ovf_set_wins", int'(fifo_overflow), 1);
    step(1, 1, 0, 0, 1);
    chk("full_wr_rd_count", int'(fifo_count), 15);

    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    chk("empty_wr_rd_count", int'(fifo_count), 1);
    chk("unf_set", int'(fifo_underflow), 1);
    step(1, 0, 0, 0, 1);
    chk("unf_legacy_clr", int'(l_unf), 0);
    chk("unf_sticky_hold", int'(fifo_underflow), 1);

    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0, 1);
    chk("wrap_count", int'(fifo_count), 3);
    chk("wrap_wptr", int'(wptr), 11);

    step(0, 0, 0, 0, 0);
    af_level = 5'd12; ae_level = 5'd2;
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 1);
    chk("af_at_12", int'(fifo_almost_full), 1);
    step(0, 1, 0, 0, 1);
    chk("af_at_11", int'(fifo_almost_full), 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 1);
    chk("ae_at_2", int'(fifo_almost_empty), 1);
    step(0, 0, 0, 1, 1);
    chk("wm_clr_peak", int'(peak_count), 2);

    af_level = 5'd20; ae_level = 5'd20;
    step(1, 0, 0, 0, 1);
    chk("af_level_gt_depth", int'(fifo_almost_full), 0);
    chk("ae_level_gt_depth", int'(fifo_almost_empty), 1);

    af_level = 5'd16; ae_level = 5'd0;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("midrst_count", int'(fifo_count), 0);
    chk("midrst_empty", int'(fifo_empty), 1);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        af_level = 5'($urandom_range(0, 20));
        ae_level = 5'($urandom_range(0, 20));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 39) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
